// File: rtl/mc_cu_if.sv
// Control bus between the multi-cycle control unit and the shared datapath/memory.
// The slave modport is the control unit's view; master is the datapath side.
interface mc_cu_if;
   logic [5:0] op;
   logic [5:0] func;
   logic       z;
   logic       mem_ack;
   logic       mem_req;
   logic       iord;
   logic       wpc;
   logic       wir;
   logic       wreg;
   logic       wmem;
   logic       regrt;
   logic       m2reg;
   logic       shift;
   logic       sext;
   logic       jal;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [3:0] aluc;
   logic [1:0] pcsource;
   logic [2:0] state;
   logic       illegal;

   modport slave (
      input  op, func, z, mem_ack,
      output mem_req, iord, wpc, wir, wreg, wmem, regrt, m2reg, shift, sext, jal,
             alusrca, alusrcb, aluc, pcsource, state, illegal
   );

   modport master (
      output op, func, z, mem_ack,
      input  mem_req, iord, wpc, wir, wreg, wmem, regrt, m2reg, shift, sext, jal,
             alusrca, alusrcb, aluc, pcsource, state, illegal
   );
endinterface

// File: rtl/mc_cu.sv
// Multi-cycle MIPS-subset control unit: IF/ID/EXE/MEM/WB sequencer with bus wait states.
// Define MC_CU_ILLEGAL_EN to trap undecoded instructions in STRAP until reset.
module mc_cu (
   input  logic     clock,
   input  logic     reset,
   mc_cu_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IF   = 3'b000,
      S_ID   = 3'b001,
      S_EXE  = 3'b010,
      S_MEM  = 3'b011,
      S_WB   = 3'b100,
      S_TRAP = 3'b101
   } state_e;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_AND = 4'b0001;
   localparam logic [3:0] ALU_OR  = 4'b0101;
   localparam logic [3:0] ALU_XOR = 4'b0010;
   localparam logic [3:0] ALU_LUI = 4'b0110;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1111;

   state_e state_q, state_d;

   logic is_r;
   logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
   logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui, i_j, i_jal;
   logic r_alu, i_alu, legal;

   assign is_r   = (bus.op == 6'b000000);
   assign i_add  = is_r & (bus.func == 6'b100000);
   assign i_sub  = is_r & (bus.func == 6'b100010);
   assign i_and  = is_r & (bus.func == 6'b100100);
   assign i_or   = is_r & (bus.func == 6'b100101);
   assign i_xor  = is_r & (bus.func == 6'b100110);
   assign i_sll  = is_r & (bus.func == 6'b000000);
   assign i_srl  = is_r & (bus.func == 6'b000010);
   assign i_sra  = is_r & (bus.func == 6'b000011);
   assign i_jr   = is_r & (bus.func == 6'b001000);
   assign i_addi = (bus.op == 6'b001000);
   assign i_andi = (bus.op == 6'b001100);
   assign i_ori  = (bus.op == 6'b001101);
   assign i_xori = (bus.op == 6'b001110);
   assign i_lw   = (bus.op == 6'b100011);
   assign i_sw   = (bus.op == 6'b101011);
   assign i_beq  = (bus.op == 6'b000100);
   assign i_bne  = (bus.op == 6'b000101);
   assign i_lui  = (bus.op == 6'b001111);
   assign i_j    = (bus.op == 6'b000010);
   assign i_jal  = (bus.op == 6'b000011);

   assign r_alu = i_add | i_sub | i_and | i_or | i_xor | i_sll | i_srl | i_sra;
   assign i_alu = i_addi | i_andi | i_ori | i_xori | i_lui;
   assign legal = r_alu | i_jr | i_alu | i_lw | i_sw | i_beq | i_bne | i_j | i_jal;

   // ALU setup shared by SEXE and SWB so the result stays stable while it is written back.
   logic [3:0] exe_aluc;
   logic [1:0] exe_srcb;
   logic       exe_shift;
   logic       exe_sext;

   always_comb begin
      exe_aluc = ALU_ADD;
      if      (i_sub)          exe_aluc = ALU_SUB;
      else if (i_and | i_andi) exe_aluc = ALU_AND;
      else if (i_or  | i_ori)  exe_aluc = ALU_OR;
      else if (i_xor | i_xori) exe_aluc = ALU_XOR;
      else if (i_lui)          exe_aluc = ALU_LUI;
      else if (i_sll)          exe_aluc = ALU_SLL;
      else if (i_srl)          exe_aluc = ALU_SRL;
      else if (i_sra)          exe_aluc = ALU_SRA;
      exe_srcb  = r_alu ? 2'b00 : 2'b10;
      exe_shift = i_sll | i_srl | i_sra;
      exe_sext  = i_addi | i_lw | i_sw;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= S_IF;
      else       state_q <= state_d;
   end

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      state_d      = state_q;
      bus.mem_req  = 1'b0;
      bus.iord     = 1'b0;
      bus.wpc      = 1'b0;
      bus.wir      = 1'b0;
      bus.wreg     = 1'b0;
      bus.wmem     = 1'b0;
      bus.regrt    = 1'b0;
      bus.m2reg    = 1'b0;
      bus.shift    = 1'b0;
      bus.sext     = 1'b0;
      bus.jal      = 1'b0;
      bus.alusrca  = 1'b0;
      bus.alusrcb  = 2'b00;
      bus.aluc     = ALU_ADD;
      bus.pcsource = 2'b00;
      bus.illegal  = 1'b0;

      unique case (state_q)
         S_IF: begin
            bus.mem_req = 1'b1;
            bus.alusrca = 1'b1;
            bus.alusrcb = 2'b01;
            if (bus.mem_ack) begin
               bus.wir = 1'b1;
               bus.wpc = 1'b1;
               state_d = S_ID;
            end
         end
         S_ID: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = 2'b11;
            bus.sext    = 1'b1;
            if (i_j | i_jal) begin
               bus.wpc      = 1'b1;
               bus.pcsource = 2'b11;
               bus.wreg     = i_jal;
               bus.jal      = i_jal;
               state_d      = S_IF;
            end else if (i_jr) begin
               bus.wpc      = 1'b1;
               bus.pcsource = 2'b10;
               state_d      = S_IF;
            end else if (legal) begin
               state_d = S_EXE;
            end else begin
`ifdef MC_CU_ILLEGAL_EN
               state_d = S_TRAP;
`else
               state_d = S_IF;
`endif
            end
         end
         S_EXE: begin
            if (i_beq | i_bne) begin
               bus.aluc     = ALU_SUB;
               bus.pcsource = 2'b01;
               bus.wpc      = (i_beq & bus.z) | (i_bne & ~bus.z);
               state_d      = S_IF;
            end else begin
               bus.aluc    = exe_aluc;
               bus.alusrcb = exe_srcb;
               bus.shift   = exe_shift;
               bus.sext    = exe_sext;
               state_d     = (i_lw | i_sw) ? S_MEM : S_WB;
            end
         end
         S_MEM: begin
            bus.mem_req = 1'b1;
            bus.iord    = 1'b1;
            bus.wmem    = i_sw;
            if (bus.mem_ack) state_d = i_lw ? S_WB : S_IF;
         end
         S_WB: begin
            bus.wreg    = 1'b1;
            bus.m2reg   = i_lw;
            bus.regrt   = i_alu | i_lw;
            bus.aluc    = exe_aluc;
            bus.alusrcb = exe_srcb;
            bus.shift   = exe_shift;
            bus.sext    = exe_sext;
            state_d     = S_IF;
         end
         S_TRAP: begin
`ifdef MC_CU_ILLEGAL_EN
            bus.illegal = 1'b1;
            state_d     = S_TRAP;
`else
            state_d     = S_IF;
`endif
         end
         default: state_d = S_IF;
      endcase

      // NOTE: enables are combinational, so they are gated by reset itself, not just by the state flop.
      if (reset) begin
         bus.wpc     = 1'b0;
         bus.wir     = 1'b0;
         bus.wreg    = 1'b0;
         bus.wmem    = 1'b0;
         bus.mem_req = 1'b0;
         bus.illegal = 1'b0;
      end
   end

   assign bus.state = state_q;

endmodule

// File: tb/tb_mc_cu.sv
// Directed self-checking bench for mc_cu; every output is packed into one vector and
// compared against hand-computed control words.
module tb_mc_cu;

   logic clock;
   logic reset;
   mc_cu_if bus ();

   mc_cu dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Observed control word layout (msb..lsb):
   // mem_req iord wpc wir wreg wmem regrt m2reg shift sext jal alusrca alusrcb[2] aluc[4] pcsource[2] state[3] illegal
   logic [23:0] obs;
   assign obs = {bus.mem_req, bus.iord, bus.wpc, bus.wir, bus.wreg, bus.wmem, bus.regrt,
                 bus.m2reg, bus.shift, bus.sext, bus.jal, bus.alusrca, bus.alusrcb,
                 bus.aluc, bus.pcsource, bus.state, bus.illegal};

   localparam logic [23:0] M_MREQ  = 24'h800000;
   localparam logic [23:0] M_IORD  = 24'h400000;
   localparam logic [23:0] M_WPC   = 24'h200000;
   localparam logic [23:0] M_WIR   = 24'h100000;
   localparam logic [23:0] M_WREG  = 24'h080000;
   localparam logic [23:0] M_WMEM  = 24'h040000;
   localparam logic [23:0] M_REGRT = 24'h020000;
   localparam logic [23:0] M_M2REG = 24'h010000;
   localparam logic [23:0] M_SHIFT = 24'h008000;
   localparam logic [23:0] M_SEXT  = 24'h004000;
   localparam logic [23:0] M_JAL   = 24'h002000;
   localparam logic [23:0] M_SRCA  = 24'h001000;
   localparam logic [23:0] SRB_4   = 24'h000400;
   localparam logic [23:0] SRB_IMM = 24'h000800;
   localparam logic [23:0] SRB_BR  = 24'h000C00;
   localparam logic [23:0] ALC_SUB = 24'h000100;
   localparam logic [23:0] ALC_OR  = 24'h000140;
   localparam logic [23:0] ALC_SRA = 24'h0003C0;
   localparam logic [23:0] PCS_BR  = 24'h000010;
   localparam logic [23:0] PCS_RS  = 24'h000020;
   localparam logic [23:0] PCS_JA  = 24'h000030;
   localparam logic [23:0] ST_ID   = 24'h000002;
   localparam logic [23:0] ST_EXE  = 24'h000004;
   localparam logic [23:0] ST_MEM  = 24'h000006;
   localparam logic [23:0] ST_WB   = 24'h000008;
   localparam logic [23:0] ST_TRAP = 24'h00000A;
   localparam logic [23:0] ST_MASK = 24'h00000E;
   localparam logic [23:0] M_ILL   = 24'h000001;

   localparam logic [23:0] IF_ACK  = M_MREQ | M_WPC | M_WIR | M_SRCA | SRB_4;
   localparam logic [23:0] IF_WAIT = M_MREQ | M_SRCA | SRB_4;
   localparam logic [23:0] ID_BASE = M_SRCA | SRB_BR | M_SEXT | ST_ID;
   localparam logic [23:0] EN_MASK = M_WPC | M_WIR | M_WREG | M_WMEM | M_MREQ | M_ILL;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_BAD  = 6'b111111;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SRA   = 6'b000011;
   localparam logic [5:0] F_JR    = 6'b001000;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [23:0] o, input logic [23:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   // Drive inputs just after the falling edge; outputs are then checked mid-cycle.
   task automatic step(input logic [5:0] o, input logic [5:0] f, input logic ack, input logic zz);
      @(negedge clock);
      bus.op      = o;
      bus.func    = f;
      bus.mem_ack = ack;
      bus.z       = zz;
      #1;
   endtask

   initial begin
      reset       = 1'b1;
      bus.op      = OP_R;
      bus.func    = F_ADD;
      bus.z       = 1'b0;
      bus.mem_ack = 1'b1;
      #3;
      chk("rst_enables", obs & EN_MASK, 24'h0);
      chk("rst_state", obs & ST_MASK, 24'h0);
      @(negedge clock);
      chk("rst_hold_enables", obs & EN_MASK, 24'h0);
      bus.mem_ack = 1'b0;
      reset       = 1'b0;

      // add: SIF, SID, SEXE, SWB
      step(OP_R, F_ADD, 1'b1, 1'b0); chk("add_if", obs, IF_ACK);
      step(OP_R, F_ADD, 1'b1, 1'b0); chk("add_id", obs, ID_BASE);
      step(OP_R, F_ADD, 1'b1, 1'b0); chk("add_exe", obs, ST_EXE);
      step(OP_R, F_ADD, 1'b1, 1'b0); chk("add_wb", obs, M_WREG | ST_WB);

      // lw with one fetch wait and two memory waits
      step(OP_LW, 6'h0, 1'b0, 1'b0); chk("lw_if_wait", obs, IF_WAIT);
      step(OP_LW, 6'h0, 1'b1, 1'b0); chk("lw_if", obs, IF_ACK);
      step(OP_LW, 6'h0, 1'b1, 1'b0); chk("lw_id", obs, ID_BASE);
      step(OP_LW, 6'h0, 1'b0, 1'b0); chk("lw_exe", obs, SRB_IMM | M_SEXT | ST_EXE);
      step(OP_LW, 6'h0, 1'b0, 1'b0); chk("lw_mem_w1", obs, M_MREQ | M_IORD | ST_MEM);
      step(OP_LW, 6'h0, 1'b0, 1'b0); chk("lw_mem_w2", obs, M_MREQ | M_IORD | ST_MEM);
      step(OP_LW, 6'h0, 1'b1, 1'b0); chk("lw_mem_ack", obs, M_MREQ | M_IORD | ST_MEM);
      step(OP_LW, 6'h0, 1'b1, 1'b0); chk("lw_wb", obs, M_WREG | M_M2REG | M_REGRT | SRB_IMM | M_SEXT | ST_WB);

      // beq taken, beq not taken, bne taken
      step(OP_BEQ, 6'h0, 1'b1, 1'b1); chk("beq1_if", obs, IF_ACK);
      step(OP_BEQ, 6'h0, 1'b1, 1'b1); chk("beq1_id", obs, ID_BASE);
      step(OP_BEQ, 6'h0, 1'b1, 1'b1); chk("beq1_exe", obs, ALC_SUB | PCS_BR | M_WPC | ST_EXE);
      step(OP_BEQ, 6'h0, 1'b1, 1'b0); chk("beq0_if", obs, IF_ACK);
      step(OP_BEQ, 6'h0, 1'b1, 1'b0); chk("beq0_id", obs, ID_BASE);
      step(OP_BEQ, 6'h0, 1'b1, 1'b0); chk("beq0_exe", obs, ALC_SUB | PCS_BR | ST_EXE);
      step(OP_BNE, 6'h0, 1'b1, 1'b0); chk("bne_if", obs, IF_ACK);
      step(OP_BNE, 6'h0, 1'b1, 1'b0); chk("bne_id", obs, ID_BASE);
      step(OP_BNE, 6'h0, 1'b1, 1'b0); chk("bne_exe", obs, ALC_SUB | PCS_BR | M_WPC | ST_EXE);

      // jumps finish in SID
      step(OP_JAL, 6'h0, 1'b1, 1'b0); chk("jal_if", obs, IF_ACK);
      step(OP_JAL, 6'h0, 1'b1, 1'b0); chk("jal_id", obs, ID_BASE | M_WPC | M_WREG | M_JAL | PCS_JA);
      step(OP_J, 6'h0, 1'b1, 1'b0);   chk("j_if", obs, IF_ACK);
      step(OP_J, 6'h0, 1'b1, 1'b0);   chk("j_id", obs, ID_BASE | M_WPC | PCS_JA);
      step(OP_R, F_JR, 1'b1, 1'b0);   chk("jr_if", obs, IF_ACK);
      step(OP_R, F_JR, 1'b1, 1'b0);   chk("jr_id", obs, ID_BASE | M_WPC | PCS_RS);

      // I-type: addi sign-extends, ori does not
      step(OP_ADDI, 6'h0, 1'b1, 1'b0); chk("addi_if", obs, IF_ACK);
      step(OP_ADDI, 6'h0, 1'b1, 1'b0); chk("addi_id", obs, ID_BASE);
      step(OP_ADDI, 6'h0, 1'b1, 1'b0); chk("addi_exe", obs, SRB_IMM | M_SEXT | ST_EXE);
      step(OP_ADDI, 6'h0, 1'b1, 1'b0); chk("addi_wb", obs, M_WREG | M_REGRT | SRB_IMM | M_SEXT | ST_WB);
      step(OP_ORI, 6'h0, 1'b1, 1'b0);  chk("ori_if", obs, IF_ACK);
      step(OP_ORI, 6'h0, 1'b1, 1'b0);  chk("ori_id", obs, ID_BASE);
      step(OP_ORI, 6'h0, 1'b1, 1'b0);  chk("ori_exe", obs, SRB_IMM | ALC_OR | ST_EXE);
      step(OP_ORI, 6'h0, 1'b1, 1'b0);  chk("ori_wb", obs, M_WREG | M_REGRT | SRB_IMM | ALC_OR | ST_WB);

      // sra uses the shift-amount path
      step(OP_R, F_SRA, 1'b1, 1'b0); chk("sra_if", obs, IF_ACK);
      step(OP_R, F_SRA, 1'b1, 1'b0); chk("sra_id", obs, ID_BASE);
      step(OP_R, F_SRA, 1'b1, 1'b0); chk("sra_exe", obs, M_SHIFT | ALC_SRA | ST_EXE);
      step(OP_R, F_SRA, 1'b1, 1'b0); chk("sra_wb", obs, M_WREG | M_SHIFT | ALC_SRA | ST_WB);

      // sw aborted by reset while waiting in SMEM
      step(OP_SW, 6'h0, 1'b1, 1'b0); chk("sw_if", obs, IF_ACK);
      step(OP_SW, 6'h0, 1'b1, 1'b0); chk("sw_id", obs, ID_BASE);
      step(OP_SW, 6'h0, 1'b0, 1'b0); chk("sw_exe", obs, SRB_IMM | M_SEXT | ST_EXE);
      step(OP_SW, 6'h0, 1'b0, 1'b0); chk("sw_mem_wait", obs, M_MREQ | M_IORD | M_WMEM | ST_MEM);
      #1 reset = 1'b1;
      #1 chk("sw_rst_abort", obs & (EN_MASK | ST_MASK), 24'h0);
      @(negedge clock);
      bus.op      = OP_R;
      bus.func    = F_ADD;
      bus.mem_ack = 1'b1;
      reset       = 1'b0;
      #1 chk("post_rst_if", obs, IF_ACK);
      step(OP_R, F_ADD, 1'b1, 1'b0); chk("post_rst_id", obs, ID_BASE);
      step(OP_R, F_ADD, 1'b1, 1'b0); chk("post_rst_exe", obs, ST_EXE);
      step(OP_R, F_ADD, 1'b1, 1'b0); chk("post_rst_wb", obs, M_WREG | ST_WB);

      // undecoded opcode
      step(OP_BAD, 6'h0, 1'b1, 1'b0); chk("bad_if", obs, IF_ACK);
      step(OP_BAD, 6'h0, 1'b1, 1'b0); chk("bad_id", obs, ID_BASE);
`ifdef MC_CU_ILLEGAL_EN
      for (int i = 0; i < 10; i++) begin
         step(OP_BAD, 6'h0, 1'b1, 1'b0);
         chk($sformatf("bad_trap_%0d", i), obs, M_ILL | ST_TRAP);
      end
`else
      step(OP_BAD, 6'h0, 1'b1, 1'b0); chk("bad_back_if", obs, IF_ACK);
      step(OP_BAD, 6'h0, 1'b1, 1'b0); chk("bad_nop_id", obs, ID_BASE);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
